// File: rtl/mem1_pkg.sv
// ----------------------------------------------------------------------------
// mem1_pkg
// Shared definitions for the mem1 (whitened-data RAM) port controller:
// block geometry constants and the controller state encoding.
// ----------------------------------------------------------------------------
package mem1_pkg;

    localparam int unsigned MEM1_DATA_W        = 32;
    localparam int unsigned MEM1_ADDR_W        = 14;
    localparam int unsigned MEM1_DEPTH         = 250;
    localparam int unsigned MEM1_RD_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWrite = 2'd1,
        StRead  = 2'd2,
        StDone  = 2'd3
    } mem1_state_e;

endpackage

// File: rtl/mem1_rd_fifo.sv
// ----------------------------------------------------------------------------
// mem1_rd_fifo
// Small synchronous FIFO holding RAM read returns until the FastICA core
// accepts them. Flush empties it in one cycle and wins over push/pop.
//
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   i_push   in   write i_wdata (ignored when full)
//   i_pop    in   drop head word (ignored when empty)
//   i_flush  in   discard all contents
//   i_wdata  in   word to push
//   o_count  out  number of stored words
//   o_head   out  oldest word, forced to 0 while empty
// ----------------------------------------------------------------------------
module mem1_rd_fifo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_flush,
    input  logic [DATA_W-1:0]      i_wdata,
    output logic [$clog2(DEPTH):0] o_count,
    output logic [DATA_W-1:0]      o_head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign w_do_push = i_push & ~i_flush & (r_count != CNT_W'(DEPTH));
    assign w_do_pop  = i_pop  & ~i_flush & (r_count != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    assign o_count = r_count;
    assign o_head  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;

endmodule

// File: rtl/mem1_port_ctrl.sv
// ----------------------------------------------------------------------------
// mem1_port_ctrl
// Responder-side port controller for the whitened-data RAM. Writes a block
// from the whitening stream, or reads a block back to FastICA through a
// credit-controlled return FIFO, under control of the main controller.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   go_ram1, rw, new_one        operation command / direction / restart
//   address_sel_mem1            block base address (sampled at start)
//   wr_valid, wr_data, wr_ready whitening sample stream in
//   rd_valid, rd_data, rd_ready FastICA sample stream out
//   mem_en, mem_we, mem_addr,   registered RAM command
//   mem_wdata
//   mem_rdata                   RAM read data, one cycle after a read command
//   busy, done                  status to the main controller
// ----------------------------------------------------------------------------
module mem1_port_ctrl
    import mem1_pkg::*;
#(
    parameter int unsigned DATA_W        = MEM1_DATA_W,
    parameter int unsigned ADDR_W        = MEM1_ADDR_W,
    parameter int unsigned DEPTH         = MEM1_DEPTH,
    parameter int unsigned RD_FIFO_DEPTH = MEM1_RD_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go_ram1,
    input  logic              rw,
    input  logic              new_one,
    input  logic [ADDR_W-1:0] address_sel_mem1,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              rd_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned FCNT_W = $clog2(RD_FIFO_DEPTH) + 1;
    localparam int unsigned OUT_W  = $clog2(RD_FIFO_DEPTH + 1);
    localparam int unsigned CRD_W  = FCNT_W + 1;

    mem1_state_e       r_state, w_state_d;
    logic [ADDR_W-1:0] r_base, w_base_d;
    logic [CNT_W-1:0]  r_offset, w_offset_d;
    logic [CNT_W-1:0]  r_pop_cnt, w_pop_cnt_d;
    logic [OUT_W-1:0]  r_outst, w_outst_d;
    logic              r_mem_en, w_mem_en_d;
    logic              r_mem_we, w_mem_we_d;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_d;
    logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_d;
    logic              r_ret_valid, w_ret_valid_d;

    logic [FCNT_W-1:0] w_fifo_count;
    logic [DATA_W-1:0] w_fifo_head;
    logic              w_busy;
    logic              w_cancel;
    logic              w_push;
    logic              w_pop;
    logic              w_flush;
    logic              w_issue;
    logic [CRD_W-1:0]  w_credit_used;
    logic [ADDR_W-1:0] w_cur_addr;

    assign w_busy     = (r_state == StWrite) || (r_state == StRead);
    // Abort or restart: every read still in flight must be dropped.
    assign w_cancel   = w_busy & (~go_ram1 | new_one);
    assign w_cur_addr = r_base + ADDR_W'(r_offset);
    assign w_pop      = (w_fifo_count != '0) & rd_ready;
    // A return is pushed only if it was not cancelled on its way back.
    assign w_push     = r_ret_valid & ~w_cancel;

    // FIFO slots already claimed after this edge's pop; an issue needs one spare.
    assign w_credit_used = CRD_W'(w_fifo_count) + CRD_W'(r_outst) - CRD_W'(w_pop);
    assign w_issue = (r_state == StRead) & ~w_cancel & (r_offset < CNT_W'(DEPTH))
                   & (w_credit_used < CRD_W'(RD_FIFO_DEPTH));

    assign w_ret_valid_d = r_mem_en & ~r_mem_we & ~w_cancel;

    always_comb begin
        w_state_d     = r_state;
        w_base_d      = r_base;
        w_offset_d    = r_offset;
        w_pop_cnt_d   = r_pop_cnt;
        w_outst_d     = r_outst;
        w_mem_en_d    = 1'b0;
        w_mem_we_d    = 1'b0;
        w_mem_addr_d  = r_mem_addr;
        w_mem_wdata_d = r_mem_wdata;
        w_flush       = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (go_ram1) begin
                    w_base_d    = address_sel_mem1;
                    w_offset_d  = '0;
                    w_pop_cnt_d = '0;
                    w_outst_d   = '0;
                    w_state_d   = rw ? StWrite : StRead;
                end
            end
            StWrite: begin
                if (!go_ram1) begin
                    w_state_d = StIdle;
                    w_flush   = 1'b1;
                    w_outst_d = '0;
                end else if (new_one) begin
                    w_offset_d = '0;
                    w_flush    = 1'b1;
                end else if (wr_valid) begin
                    w_mem_en_d    = 1'b1;
                    w_mem_we_d    = 1'b1;
                    w_mem_addr_d  = w_cur_addr;
                    w_mem_wdata_d = wr_data;
                    w_offset_d    = r_offset + CNT_W'(1);
                    if (r_offset == CNT_W'(DEPTH - 1)) begin
                        w_state_d = StDone;
                    end
                end
            end
            StRead: begin
                if (!go_ram1) begin
                    w_state_d = StIdle;
                    w_flush   = 1'b1;
                    w_outst_d = '0;
                end else if (new_one) begin
                    w_offset_d  = '0;
                    w_pop_cnt_d = '0;
                    w_outst_d   = '0;
                    w_flush     = 1'b1;
                end else begin
                    if (w_issue) begin
                        w_mem_en_d   = 1'b1;
                        w_mem_addr_d = w_cur_addr;
                        w_offset_d   = r_offset + CNT_W'(1);
                    end
                    w_outst_d = r_outst + OUT_W'(w_issue) - OUT_W'(w_push);
                    if (w_pop) begin
                        w_pop_cnt_d = r_pop_cnt + CNT_W'(1);
                        if (r_pop_cnt == CNT_W'(DEPTH - 1)) begin
                            w_state_d = StDone;
                        end
                    end
                end
            end
            StDone: begin
                if (!go_ram1) begin
                    w_state_d = StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base      <= '0;
            r_offset    <= '0;
            r_pop_cnt   <= '0;
            r_outst     <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_ret_valid <= 1'b0;
        end else begin
            r_base      <= w_base_d;
            r_offset    <= w_offset_d;
            r_pop_cnt   <= w_pop_cnt_d;
            r_outst     <= w_outst_d;
            r_mem_en    <= w_mem_en_d;
            r_mem_we    <= w_mem_we_d;
            r_mem_addr  <= w_mem_addr_d;
            r_mem_wdata <= w_mem_wdata_d;
            r_ret_valid <= w_ret_valid_d;
        end
    end

    mem1_rd_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (RD_FIFO_DEPTH)
    ) u_rd_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_wdata (mem_rdata),
        .o_count (w_fifo_count),
        .o_head  (w_fifo_head)
    );

    assign wr_ready  = (r_state == StWrite);
    assign busy      = w_busy;
    assign done      = (r_state == StDone);
    assign rd_valid  = (w_fifo_count != '0);
    assign rd_data   = w_fifo_head;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem1_port_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mem1_port_ctrl
// Self-checking bench for mem1_port_ctrl. A behavioural RAM sits on the
// memory port; a reference memory image and expected-word queues predict
// every RAM write and every word popped by the FastICA side.
// ----------------------------------------------------------------------------
module tb_mem1_port_ctrl;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 14;
    localparam int unsigned DEPTH = 250;
    localparam int unsigned FD    = 4;
    localparam int          AMOD  = 1 << AW;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          go_ram1;
    logic          rw;
    logic          new_one;
    logic [AW-1:0] address_sel_mem1;
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_ready;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;
    logic          done;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] ram     [AMOD];
    logic [DW-1:0] ref_mem [AMOD];
    wr_t           exp_wr  [$];

    always #5 clk = ~clk;

    mem1_port_ctrl #(
        .DATA_W        (DW),
        .ADDR_W        (AW),
        .DEPTH         (DEPTH),
        .RD_FIFO_DEPTH (FD)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .go_ram1          (go_ram1),
        .rw               (rw),
        .new_one          (new_one),
        .address_sel_mem1 (address_sel_mem1),
        .wr_valid         (wr_valid),
        .wr_data          (wr_data),
        .wr_ready         (wr_ready),
        .rd_valid         (rd_valid),
        .rd_data          (rd_data),
        .rd_ready         (rd_ready),
        .mem_en           (mem_en),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_rdata        (mem_rdata),
        .busy             (busy),
        .done             (done)
    );

    // 1-cycle-latency RAM; garbage on rdata when no read so stray pushes show up.
    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            ram[mem_addr] = mem_wdata;
        end
        if (mem_en && !mem_we) begin
            mem_rdata <= ram[mem_addr];
        end else begin
            mem_rdata <= $urandom;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_zero(input string p);
        check_eq({p, "_busy"},      busy,      0);
        check_eq({p, "_done"},      done,      0);
        check_eq({p, "_wr_ready"},  wr_ready,  0);
        check_eq({p, "_rd_valid"},  rd_valid,  0);
        check_eq({p, "_rd_data"},   rd_data,   0);
        check_eq({p, "_mem_en"},    mem_en,    0);
        check_eq({p, "_mem_we"},    mem_we,    0);
        check_eq({p, "_mem_addr"},  mem_addr,  0);
        check_eq({p, "_mem_wdata"}, mem_wdata, 0);
    endtask

    task automatic wr_bus_check(input bit exp_pulse);
        wr_t e;
        check_eq("wr_pulse", mem_en & mem_we, exp_pulse);
        if (mem_en && mem_we && exp_wr.size() != 0) begin
            e = exp_wr.pop_front();
            check_eq("wr_addr", mem_addr, e.a);
            check_eq("wr_data", mem_wdata, e.d);
        end
    endtask

    // Writes one block from base; abort_after >= 0 drops go_ram1 after that many handshakes.
    task automatic do_write(input int base, input int abort_after, input bit ramp);
        int            hs = 0;
        int            k = 0;
        bit            prev_hs = 1'b0;
        logic [DW-1:0] d;
        wr_t           e;
        exp_wr.delete();
        @(negedge clk);
        go_ram1 = 1'b1;
        rw = 1'b1;
        address_sel_mem1 = AW'(base);
        wr_valid = 1'b0;
        @(negedge clk);
        wr_bus_check(1'b0);
        while (hs < DEPTH && hs != abort_after && k < 3000) begin
            check_eq("wr_ready", wr_ready, 1);
            check_eq("wr_busy", busy, 1);
            wr_valid = ramp ? 1'b1 : ($urandom_range(1) == 1);
            d = ramp ? DW'(hs) : $urandom;
            wr_data = d;
            prev_hs = wr_valid;
            if (wr_valid) begin
                e.a = AW'(base + hs);
                e.d = d;
                exp_wr.push_back(e);
                ref_mem[e.a] = d;
                hs++;
            end
            @(negedge clk);
            k++;
            wr_bus_check(prev_hs);
        end
        if (abort_after >= 0) begin
            check_eq("wr_abort_count", hs, abort_after);
            go_ram1 = 1'b0;
            wr_valid = 1'b1;
            wr_data = $urandom;
            @(negedge clk);
            wr_bus_check(1'b0);
            check_eq("abort_busy", busy, 0);
            check_eq("abort_done", done, 0);
            check_eq("abort_wr_ready", wr_ready, 0);
            wr_valid = 1'b0;
            @(negedge clk);
            wr_bus_check(1'b0);
            check_eq("abort_done_later", done, 0);
        end else begin
            check_eq("wr_count", hs, DEPTH);
            check_eq("wr_done", done, 1);
            check_eq("wr_done_busy", busy, 0);
            check_eq("wr_done_ready", wr_ready, 0);
            wr_valid = 1'b0;
            go_ram1 = 1'b0;
            @(negedge clk);
            wr_bus_check(1'b0);
            check_eq("wr_idle_done", done, 0);
        end
        check_eq("wr_pending", exp_wr.size(), 0);
    endtask

    // mode 0: rd_ready held high; mode 1: rd_ready high one cycle in three (random).
    task automatic do_read(input int base, input int mode, input int restart_after,
                           input int rst_after, input bit chk_lat);
        logic [DW-1:0] exp_rd [$];
        int            pops = 0;
        int            issued = 0;
        int            k = 0;
        int            first_k = -1;
        bit            restarted = 1'b0;
        bit            aborted = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            exp_rd.push_back(ref_mem[AW'(base + i)]);
        end
        @(negedge clk);
        go_ram1 = 1'b1;
        rw = 1'b0;
        address_sel_mem1 = AW'(base);
        rd_ready = 1'b0;
        while (pops < DEPTH && k < 6000) begin
            @(negedge clk);
            k++;
            new_one = 1'b0;
            if (mem_en) begin
                check_eq("rd_mem_we", mem_we, 0);
                issued++;
            end
            check_eq("rd_credit", (issued - pops) <= FD, 1);
            if (rd_valid && first_k < 0) begin
                first_k = k;
                if (chk_lat) begin
                    check_eq("rd_latency", k, 4);
                end
            end
            if (mode == 0 && first_k >= 0) begin
                check_eq("rd_stream_gap", rd_valid, 1);
            end
            if (restart_after >= 0 && !restarted && pops == restart_after) begin
                new_one = 1'b1;
                rd_ready = 1'b0;
                restarted = 1'b1;
                pops = 0;
                issued = 0;
                first_k = -1;
                exp_rd.delete();
                for (int i = 0; i < DEPTH; i++) begin
                    exp_rd.push_back(ref_mem[AW'(base + i)]);
                end
                continue;
            end
            if (rst_after >= 0 && pops == rst_after) begin
                rd_ready = 1'b0;
                #2 rst = 1'b1;
                #1 check_zero("rst_async");
                go_ram1 = 1'b0;
                @(negedge clk);
                check_zero("rst_hold");
                rst = 1'b0;
                aborted = 1'b1;
                break;
            end
            rd_ready = (mode == 0) ? 1'b1 : ($urandom_range(2) == 0);
            if (rd_valid && rd_ready) begin
                if (exp_rd.size() == 0) begin
                    check_eq("rd_extra", rd_valid, 0);
                end else begin
                    check_eq("rd_data", rd_data, exp_rd.pop_front());
                end
                pops++;
            end
        end
        if (!aborted) begin
            check_eq("rd_pop_count", pops, DEPTH);
            @(negedge clk);
            rd_ready = 1'b0;
            check_eq("rd_done", done, 1);
            check_eq("rd_done_busy", busy, 0);
            check_eq("rd_done_valid", rd_valid, 0);
            check_eq("rd_done_mem_en", mem_en, 0);
            go_ram1 = 1'b0;
            @(negedge clk);
            check_eq("rd_idle_done", done, 0);
            check_eq("rd_idle_busy", busy, 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d checks so far", n_cmp);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        go_ram1 = 1'b0;
        rw = 1'b0;
        new_one = 1'b0;
        address_sel_mem1 = '0;
        wr_valid = 1'b0;
        wr_data = '0;
        rd_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check_zero("idle");

        do_write(0, -1, 1'b1);            // data i at address i, back to back
        do_read(0, 0, -1, -1, 1'b1);      // no backpressure, latency and streaming
        do_read(0, 1, -1, -1, 1'b0);      // random 1-of-3 backpressure
        do_write(16380, -1, 1'b0);        // wraps past the top of the address space
        do_read(16380, 1, -1, -1, 1'b0);
        do_write(5000, 100, 1'b0);        // abort after 100 words
        do_read(16380, 0, 50, -1, 1'b0);  // restart after 50 pops
        do_read(0, 0, -1, 30, 1'b0);      // async reset mid-read
        do_read(0, 0, -1, -1, 1'b1);      // clean read after reset

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
